matmul_c_result_writer: RTL and testbench

- Consumer side of the C-output interface of the composed 16x16 int8 matmul.
- Accepts result rows from the two right-column 8x8 slices (0_1 and 1_1), each presented as {c_data, c_addr, c_data_available}.
- Buffers each stream in a per-lane FIFO and round-robin-arbitrates both onto a single write port of the C result RAM.
- Supports valid/ready backpressure and reports completion once all 2*MAT_MUL_SIZE rows are written.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/c_lane_fifo.sv | 80 ++++++++
 rtl/matmul_c_result_writer.sv | 140 ++++++++++++++
 tb/tb_matmul_c_result_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the composed 16x16 int8 matmul C-output path.
package matmul_pkg;

    localparam int unsigned DWIDTH          = 8;
    localparam int unsigned MAT_MUL_SIZE    = 8;
    localparam int unsigned AWIDTH          = 10;
    localparam int unsigned ROW_W           = MAT_MUL_SIZE * DWIDTH;
    localparam int unsigned ROWS_PER_RESULT = 2 * MAT_MUL_SIZE;
    localparam int unsigned CNT_W           = $clog2(ROWS_PER_RESULT + 1);

    // One result row as carried through the lane FIFOs and the output slot.
    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [ROW_W-1:0]  data;
    } c_row_t;

    // Arbitration pointer: which lane wins when both have rows waiting.
    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

endpackage

// File: rtl/c_lane_fifo.sv
// Synchronous first-word-fall-through FIFO for one C-output lane.
module c_lane_fifo
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear_i,
    input  logic   push_i,
    input  c_row_t push_row_i,
    input  logic   pop_i,
    output c_row_t head_c_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FCW   = PTR_W + 1;

    c_row_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push_i & ~full_q & ~clear_i;
    assign do_pop_c  = pop_i & ~empty_q & ~clear_i;
    assign head_c_o  = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

    // Next pointer/occupancy state; clear wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_d = count_q + FCW'(1);
                2'b01:   count_d = count_q - FCW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == FCW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= push_row_i;
    end

endmodule

// File: rtl/matmul_c_result_writer.sv
// Collects C rows from slices 0_1 and 1_1, arbitrates them onto one RAM write port.
module matmul_c_result_writer
    import matmul_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  c_data_0_1,
    input  logic [AWIDTH-1:0] c_addr_0_1,
    input  logic              c_data_0_1_available,
    input  logic [ROW_W-1:0]  c_data_1_1,
    input  logic [AWIDTH-1:0] c_addr_1_1,
    input  logic              c_data_1_1_available,
    output logic              ram_wr_en,
    output logic [AWIDTH-1:0] ram_wr_addr,
    output logic [ROW_W-1:0]  ram_wr_data,
    input  logic              ram_ready,
    output logic              done_write,
    output logic              overflow,
    output logic [CNT_W-1:0]  rows_written
);

    c_row_t           head0_c, head1_c;
    logic             full0, full1;
    logic             empty0, empty1;
    logic             pop0_c, pop1_c;
    logic             push0_c, push1_c;
    logic             accept_c;

    logic             slot_vld_q, slot_vld_d;
    c_row_t           slot_row_q, slot_row_d;
    lane_e            ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    // Rows arriving alongside start belong to the abandoned collection.
    assign push0_c = c_data_0_1_available & ~start;
    assign push1_c = c_data_1_1_available & ~start;

    c_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_lane0 (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (start),
        .push_i     (push0_c),
        .push_row_i ('{addr: c_addr_0_1, data: c_data_0_1}),
        .pop_i      (pop0_c),
        .head_c_o   (head0_c),
        .full_o     (full0),
        .empty_o    (empty0)
    );

    c_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_lane1 (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (start),
        .push_i     (push1_c),
        .push_row_i ('{addr: c_addr_1_1, data: c_data_1_1}),
        .pop_i      (pop1_c),
        .head_c_o   (head1_c),
        .full_o     (full1),
        .empty_o    (empty1)
    );

    // Arbitration, output slot refill, completion counting and overflow tracking.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_row_d = slot_row_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        pop0_c     = 1'b0;
        pop1_c     = 1'b0;
        accept_c   = 1'b0;

        if (start) begin
            slot_vld_d = 1'b0;
            slot_row_d = '0;
            ptr_d      = LANE0;
            cnt_d      = '0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            accept_c = slot_vld_q & ram_ready;

            if (!slot_vld_q || accept_c) begin
                if (!empty0 && (empty1 || ptr_q == LANE0)) begin
                    pop0_c     = 1'b1;
                    slot_vld_d = 1'b1;
                    slot_row_d = head0_c;
                    ptr_d      = LANE1;
                end else if (!empty1) begin
                    pop1_c     = 1'b1;
                    slot_vld_d = 1'b1;
                    slot_row_d = head1_c;
                    ptr_d      = LANE0;
                end else begin
                    slot_vld_d = 1'b0;
                end
            end

            if (accept_c && cnt_q != CNT_W'(ROWS_PER_RESULT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            done_d = done_q | (cnt_d == CNT_W'(ROWS_PER_RESULT));
            ovf_d  = ovf_q | (c_data_0_1_available & full0)
                           | (c_data_1_1_available & full1);
        end
    end

    // Output slot and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_vld_q <= 1'b0;
            slot_row_q <= '0;
            ptr_q      <= LANE0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_row_q <= slot_row_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ram_wr_en    = slot_vld_q;
    assign ram_wr_addr  = slot_row_q.addr;
    assign ram_wr_data  = slot_row_q.data;
    assign done_write   = done_q;
    assign overflow     = ovf_q;
    assign rows_written = cnt_q;

endmodule

// File: tb/tb_matmul_c_result_writer.sv
// Directed and randomized bench for matmul_c_result_writer with a queue-based reference model.
module tb_matmul_c_result_writer;
    import matmul_pkg::*;

    localparam int unsigned FD = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ROW_W-1:0]  c_data_0_1, c_data_1_1;
    logic [AWIDTH-1:0] c_addr_0_1, c_addr_1_1;
    logic              c_data_0_1_available, c_data_1_1_available;
    logic              ram_wr_en;
    logic [AWIDTH-1:0] ram_wr_addr;
    logic [ROW_W-1:0]  ram_wr_data;
    logic              ram_ready;
    logic              done_write;
    logic              overflow;
    logic [CNT_W-1:0]  rows_written;

    always #5 clk = ~clk;

    matmul_c_result_writer #(.FIFO_DEPTH(FD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .c_data_0_1           (c_data_0_1),
        .c_addr_0_1           (c_addr_0_1),
        .c_data_0_1_available (c_data_0_1_available),
        .c_data_1_1           (c_data_1_1),
        .c_addr_1_1           (c_addr_1_1),
        .c_data_1_1_available (c_data_1_1_available),
        .ram_wr_en            (ram_wr_en),
        .ram_wr_addr          (ram_wr_addr),
        .ram_wr_data          (ram_wr_data),
        .ram_ready            (ram_ready),
        .done_write           (done_write),
        .overflow             (overflow),
        .rows_written         (rows_written)
    );

    // Reference model: rows owed to the RAM per lane, accepted-write log, status.
    int     checks = 0;
    int     errors = 0;
    c_row_t q0[$];
    c_row_t q1[$];
    int     log_addr[$];
    int     total = 0;
    bit     ovf_exp = 1'b0;
    bit     prev_stall = 1'b0;
    c_row_t prev_row;
    c_row_t nil_row;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic c_row_t mk(input int a, input int d);
        c_row_t r;
        r.addr = AWIDTH'(a);
        r.data = {MAT_MUL_SIZE{DWIDTH'(d)}};
        return r;
    endfunction

    // One clock: check status against the model, drive inputs, score the write, advance.
    task automatic cycle(input bit a0, input c_row_t r0, input bit a1, input c_row_t r1,
                         input bit rdy, input bit st);
        int     exp_cnt;
        bit     found;
        c_row_t w;
        exp_cnt = (total > int'(ROWS_PER_RESULT)) ? int'(ROWS_PER_RESULT) : total;
        check("rows_written", 64'(rows_written), 64'(exp_cnt));
        check("done_write", 64'(done_write), 64'(total >= int'(ROWS_PER_RESULT)));
        check("overflow", 64'(overflow), 64'(ovf_exp));
        if (prev_stall) begin
            check("hold_en", 64'(ram_wr_en), 64'd1);
            check("hold_addr", 64'(ram_wr_addr), 64'(prev_row.addr));
            check("hold_data", ram_wr_data, prev_row.data);
        end

        c_data_0_1_available = a0;
        c_addr_0_1           = r0.addr;
        c_data_0_1           = r0.data;
        c_data_1_1_available = a1;
        c_addr_1_1           = r1.addr;
        c_data_1_1           = r1.data;
        ram_ready            = rdy;
        start                = st;

        w.addr = ram_wr_addr;
        w.data = ram_wr_data;
        if (!st && ram_wr_en && rdy) begin
            found = 1'b0;
            if (q0.size() != 0 && q0[0] === w) begin
                void'(q0.pop_front());
                found = 1'b1;
            end else if (q1.size() != 0 && q1[0] === w) begin
                void'(q1.pop_front());
                found = 1'b1;
            end
            check("write_matches_lane_head", 64'(found), 64'd1);
            total++;
            log_addr.push_back(int'(ram_wr_addr));
        end
        prev_stall = ram_wr_en && !rdy && !st;
        prev_row   = w;

        if (st) begin
            q0.delete();
            q1.delete();
            total   = 0;
            ovf_exp = 1'b0;
        end else begin
            if (a0) q0.push_back(r0);
            if (a1) q1.push_back(r1);
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, nil_row, 1'b0, nil_row, rdy, 1'b0);
    endtask

    task automatic pulse_start();
        cycle(1'b0, nil_row, 1'b0, nil_row, 1'b1, 1'b1);
        log_addr.delete();
    endtask

    // Run with ram_ready=1 until the model owes nothing, bounded.
    task automatic drain(input string tag);
        for (int k = 0; k < 80 && (q0.size() != 0 || q1.size() != 0); k++) begin
            cycle(1'b0, nil_row, 1'b0, nil_row, 1'b1, 1'b0);
        end
        check({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
        check({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
        idle(1'b1, 1);
        check({tag, "_idle_en"}, 64'(ram_wr_en), 64'd0);
    endtask

    initial begin
        nil_row = '0;
        reset = 1'b0;
        start = 1'b0;
        ram_ready = 1'b0;
        c_data_0_1_available = 1'b0;
        c_data_1_1_available = 1'b0;
        c_addr_0_1 = '0;
        c_addr_1_1 = '0;
        c_data_0_1 = '0;
        c_data_1_1 = '0;
        repeat (2) @(negedge clk);

        check("rst_en", 64'(ram_wr_en), 64'd0);
        check("rst_addr", 64'(ram_wr_addr), 64'd0);
        check("rst_data", ram_wr_data, 64'd0);
        check("rst_done", 64'(done_write), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_rows", 64'(rows_written), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Lane 0 only, eight rows in order.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(32'h100 + i, i), 1'b0, nil_row, 1'b1, 1'b0);
            if (i == 0) check("t1_no_en_after_1", 64'(ram_wr_en), 64'd0);
            if (i == 1) begin
                check("t1_en_after_2", 64'(ram_wr_en), 64'd1);
                check("t1_first_addr", 64'(ram_wr_addr), 64'h100);
            end
        end
        drain("t1");
        check("t1_log_size", 64'(log_addr.size()), 64'd8);
        for (int k = 0; k < log_addr.size() && k < 8; k++)
            check("t1_order", 64'(log_addr[k]), 64'(32'h100 + k));
        check("t1_rows", 64'(rows_written), 64'd8);
        check("t1_done", 64'(done_write), 64'd0);

        // Both lanes together: strict alternation, completion at 16.
        pulse_start();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, mk(i, i), 1'b1, mk(32'h080 + i, 32'h40 + i), 1'b1, 1'b0);
        drain("t2");
        check("t2_log_size", 64'(log_addr.size()), 64'd16);
        for (int k = 0; k < log_addr.size() && k < 16; k++)
            check("t2_alternate", 64'(log_addr[k]),
                  64'(((k % 2) == 0) ? (k / 2) : (32'h080 + k / 2)));
        check("t2_done", 64'(done_write), 64'd1);
        check("t2_rows", 64'(rows_written), 64'd16);

        // Backpressure for 5 cycles mid-stream.
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cycle(1'b1, mk(32'h010 + i, i), 1'b1, mk(32'h090 + i, i + 8),
                             !(i >= 4 && i < 9), 1'b0);
            else cycle(1'b0, nil_row, 1'b0, nil_row, !(i >= 4 && i < 9), 1'b0);
        end
        drain("t3");
        check("t3_total", 64'(log_addr.size()), 64'd16);
        check("t3_done", 64'(done_write), 64'd1);

        // Overflow: 10 rows into lane 0 with the RAM stalled; the tenth is dropped.
        pulse_start();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, mk(32'h200 + i, i), 1'b0, nil_row, 1'b0, 1'b0);
        void'(q0.pop_back());
        ovf_exp = 1'b1;
        idle(1'b0, 1);
        check("t4_ovf", 64'(overflow), 64'd1);
        drain("t4");
        check("t4_log_size", 64'(log_addr.size()), 64'd9);
        for (int k = 0; k < log_addr.size() && k < 9; k++)
            check("t4_order", 64'(log_addr[k]), 64'(32'h200 + k));

        // start with rows buffered and a write pending.
        pulse_start();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, mk(32'h300 + i, i), 1'b0, nil_row, 1'b0, 1'b0);
        check("t5_pending", 64'(ram_wr_en), 64'd1);
        cycle(1'b1, mk(32'h3F0, 1), 1'b1, mk(32'h3F1, 2), 1'b0, 1'b1);
        check("t5_en_cleared", 64'(ram_wr_en), 64'd0);
        check("t5_rows_cleared", 64'(rows_written), 64'd0);
        idle(1'b1, 10);
        check("t5_no_stale", 64'(log_addr.size()), 64'd0);

        // Randomized traffic, kept below FIFO capacity so nothing may drop.
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            c_row_t r0, r1;
            bit     a0, a1;
            r0.addr = AWIDTH'($urandom_range(0, 511));
            r0.data = {$urandom, $urandom};
            r1.addr = AWIDTH'($urandom_range(512, 1023));
            r1.data = {$urandom, $urandom};
            a0 = ($urandom_range(0, 2) == 0) && (q0.size() < FD);
            a1 = ($urandom_range(0, 2) == 0) && (q1.size() < FD);
            cycle(a0, r0, a1, r1, $urandom_range(0, 3) != 0, 1'b0);
        end
        drain("t6");
        check("t6_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset between edges.
        pulse_start();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, mk(32'h050 + i, i), 1'b1, mk(32'h250 + i, i), 1'b1, 1'b0);
        c_data_0_1_available = 1'b0;
        c_data_1_1_available = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("t7_rst_en", 64'(ram_wr_en), 64'd0);
        check("t7_rst_addr", 64'(ram_wr_addr), 64'd0);
        check("t7_rst_data", ram_wr_data, 64'd0);
        check("t7_rst_rows", 64'(rows_written), 64'd0);
        check("t7_rst_done", 64'(done_write), 64'd0);
        check("t7_rst_ovf", 64'(overflow), 64'd0);
        q0.delete();
        q1.delete();
        log_addr.delete();
        total = 0;
        ovf_exp = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(1'b1, 10);
        check("t7_no_writes", 64'(log_addr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
